// File: rtl/gobang_pkg.sv
// rtl/gobang_pkg.sv - shared board geometry, FSM encoding and cell index helper
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int CNT_W   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return ({4'd0, row} * 8'(BOARD_N)) + {4'd0, col};
    endfunction

endpackage

// File: rtl/move_validator.sv
// rtl/move_validator.sv - combinational range and occupancy check for a move request
module move_validator
    import gobang_pkg::*;
#(
    parameter int BOARD_N = gobang_pkg::BOARD_N,
    parameter int CELLS   = gobang_pkg::CELLS
) (
    input  logic [3:0]       row,
    input  logic [3:0]       col,
    input  logic [CELLS-1:0] occupied,
    output logic             legal,
    output logic [7:0]       idx
);

    logic         in_range;
    logic [255:0] occ_ext;

    assign in_range = (row < 4'(BOARD_N)) && (col < 4'(BOARD_N));
    assign idx      = cell_idx(row, col);
    // Padding to the full 8-bit index space keeps out-of-range indices harmless;
    // the occupancy bit only matters once in_range holds.
    assign occ_ext  = {{(256-CELLS){1'b0}}, occupied};
    assign legal    = in_range && !occ_ext[idx];

endmodule

// File: rtl/board_state_ctrl.sv
// rtl/board_state_ctrl.sv - owns the stone bitmaps, commits moves and sequences the win check
module board_state_ctrl
    import gobang_pkg::*;
#(
    parameter int BOARD_N = gobang_pkg::BOARD_N,
    parameter int CELLS   = gobang_pkg::CELLS,
    parameter int CNT_W   = gobang_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [3:0]       move_row,
    input  logic [3:0]       move_col,
    output logic             move_ready,
    output logic             move_reject,
    output logic [3:0]       chk_row,
    output logic [3:0]       chk_col,
    output logic [CELLS-1:0] chk_board,
    input  logic             win_check,
    output logic [CELLS-1:0] black_board,
    output logic [CELLS-1:0] white_board,
    output logic             turn,
    output logic [CNT_W-1:0] move_count,
    output logic             game_over,
    output logic             winner,
    output logic             draw
);

    logic [1:0]       state;
    logic             legal;
    logic [7:0]       idx;
    logic [CELLS-1:0] stone_mask;
    logic [CELLS-1:0] mover_next;
    logic             accept;
    logic             reject_next;

    move_validator #(
        .BOARD_N (BOARD_N),
        .CELLS   (CELLS)
    ) u_move_validator (
        .row      (move_row),
        .col      (move_col),
        .occupied (black_board | white_board),
        .legal    (legal),
        .idx      (idx)
    );

    assign move_ready  = (state == ST_IDLE);
    assign stone_mask  = {{(CELLS-1){1'b0}}, 1'b1} << idx;
    assign mover_next  = ((turn == WHITE) ? white_board : black_board) | stone_mask;
    assign accept      = move_ready && move_valid && legal && !new_game;
    // CHECK silently ignores requests; OVER rejects every one.
    assign reject_next = !new_game && move_valid &&
                         ((move_ready && !legal) || (state == ST_OVER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            black_board <= '0;
            white_board <= '0;
            chk_row     <= '0;
            chk_col     <= '0;
            chk_board   <= '0;
            turn        <= BLACK;
            move_count  <= '0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            draw        <= 1'b0;
            move_reject <= 1'b0;
        end else if (new_game) begin
            state       <= ST_IDLE;
            black_board <= '0;
            white_board <= '0;
            chk_row     <= '0;
            chk_col     <= '0;
            chk_board   <= '0;
            turn        <= BLACK;
            move_count  <= '0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            draw        <= 1'b0;
            move_reject <= 1'b0;
        end else begin
            move_reject <= reject_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (turn == WHITE) white_board <= mover_next;
                        else               black_board <= mover_next;
                        chk_row    <= move_row;
                        chk_col    <= move_col;
                        chk_board  <= mover_next;
                        move_count <= move_count + 1'b1;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (win_check) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= turn;
                        draw      <= 1'b0;
                    end else if (move_count == CNT_W'(CELLS)) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        draw      <= 1'b1;
                    end else begin
                        turn  <= ~turn;
                        state <= ST_IDLE;
                    end
                end
                ST_OVER: begin
                    state <= ST_OVER;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb/tb_board_state_ctrl.sv - randomized self-checking bench for board_state_ctrl
module tb_board_state_ctrl;

    logic         clk;
    logic         rst;
    logic         new_game;
    logic         move_valid;
    logic [3:0]   move_row;
    logic [3:0]   move_col;
    logic         move_ready;
    logic         move_reject;
    logic [3:0]   chk_row;
    logic [3:0]   chk_col;
    logic [224:0] chk_board;
    logic         win_check;
    logic [224:0] black_board;
    logic [224:0] white_board;
    logic         turn;
    logic [7:0]   move_count;
    logic         game_over;
    logic         winner;
    logic         draw;

    board_state_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_row    (move_row),
        .move_col    (move_col),
        .move_ready  (move_ready),
        .move_reject (move_reject),
        .chk_row     (chk_row),
        .chk_col     (chk_col),
        .chk_board   (chk_board),
        .win_check   (win_check),
        .black_board (black_board),
        .white_board (white_board),
        .turn        (turn),
        .move_count  (move_count),
        .game_over   (game_over),
        .winner      (winner),
        .draw        (draw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit no_win = 1'b0;

    // Stub horizontal/vertical checker: any 5-cell window through (r,c) fully set.
    function automatic bit stub_win(input logic [224:0] b, input logic [3:0] r, input logic [3:0] c);
        int ri = int'(r);
        int ci = int'(c);
        if (ri > 14 || ci > 14) return 1'b0;
        for (int s = 0; s <= 10; s++) begin
            bit h = 1'b1;
            bit v = 1'b1;
            for (int k = 0; k < 5; k++) begin
                h &= b[ri*15 + s + k];
                v &= b[(s+k)*15 + ci];
            end
            if (h && ci >= s && ci <= s + 4) return 1'b1;
            if (v && ri >= s && ri <= s + 4) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb win_check = !no_win && stub_win(chk_board, chk_row, chk_col);

    // Reference model: 2-D grid of colours (0 empty, 1 black, 2 white).
    int mb [15][15];
    bit m_turn, m_over, m_winner, m_draw;
    int m_count;

    task automatic model_clear();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) mb[r][c] = 0;
        m_turn = 0; m_over = 0; m_winner = 0; m_draw = 0; m_count = 0;
    endtask

    function automatic logic [224:0] model_bits(input int colour);
        logic [224:0] b = '0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                if (mb[r][c] == colour) b[r*15+c] = 1'b1;
        return b;
    endfunction

    function automatic bit model_win(input int r, input int c, input int colour);
        int nh = 1;
        int nv = 1;
        for (int k = c - 1; k >= 0 && mb[r][k] == colour; k--) nh++;
        for (int k = c + 1; k < 15 && mb[r][k] == colour; k++) nh++;
        for (int k = r - 1; k >= 0 && mb[k][c] == colour; k--) nv++;
        for (int k = r + 1; k < 15 && mb[k][c] == colour; k++) nv++;
        return (nh >= 5) || (nv >= 5);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".black"},  black_board, model_bits(1));
        check({tag, ".white"},  white_board, model_bits(2));
        check({tag, ".turn"},   turn, m_turn);
        check({tag, ".count"},  move_count, m_count);
        check({tag, ".over"},   game_over, m_over);
        check({tag, ".draw"},   draw, m_draw);
        check({tag, ".ready"},  move_ready, !m_over);
        if (m_over && !m_draw) check({tag, ".winner"}, winner, m_winner);
    endtask

    task automatic start_game(input bit with_move);
        @(negedge clk);
        new_game   = 1'b1;
        move_valid = with_move;
        move_row   = 4'd7;
        move_col   = 4'd7;
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_clear();
        check("newgame.reject", move_reject, 0);
        check("newgame.chk_board", chk_board, 0);
        check_state("newgame");
    endtask

    // Drives one request and checks the commit cycle and the decision cycle.
    task automatic play(input int r, input int c);
        bit legal;
        int colour;
        legal = !m_over && r < 15 && c < 15;
        if (legal) legal = (mb[r][c] == 0);
        @(negedge clk);
        move_valid = 1'b1;
        move_row   = 4'(r);
        move_col   = 4'(c);
        @(negedge clk);
        move_valid = 1'b0;
        if (!legal) begin
            check("rej.pulse", move_reject, 1);
            check_state("rej");
            @(negedge clk);
            check("rej.drop", move_reject, 0);
        end else begin
            colour = m_turn ? 2 : 1;
            mb[r][c] = colour;
            m_count++;
            check("acc.reject", move_reject, 0);
            check("acc.ready", move_ready, 0);
            check("acc.chk_row", chk_row, r);
            check("acc.chk_col", chk_col, c);
            check("acc.chk_board", chk_board, model_bits(colour));
            check("acc.count", move_count, m_count);
            if (!no_win && model_win(r, c, colour)) begin
                m_over = 1; m_winner = m_turn;
            end else if (m_count == 225) begin
                m_over = 1; m_draw = 1;
            end else begin
                m_turn = !m_turn;
            end
            @(negedge clk);
            check_state("dec");
        end
    endtask

    task automatic script_to_brink();
        for (int i = 0; i < 4; i++) begin
            play(0, i);
            play(5, i);
        end
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0;
        move_row = '0; move_col = '0;
        model_clear();
        #12;
        check("rst.reject", move_reject, 0);
        check("rst.chk_board", chk_board, 0);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("post_rst");

        play(7, 7);
        check("b77.bit112", black_board[112], 1);
        play(7, 7);
        play(15, 3);

        start_game(1'b0);
        script_to_brink();
        play(0, 4);
        check("script.winner_black", {game_over, winner, draw}, 3'b100);
        play(3, 3);

        start_game(1'b1);
        no_win = 1'b1;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) play(r, c);
        check("fill.draw", {game_over, draw, move_count}, {2'b11, 8'd225});
        no_win = 1'b0;

        // new_game lands on the CHECK cycle of a winning move.
        start_game(1'b0);
        script_to_brink();
        @(negedge clk);
        move_valid = 1'b1; move_row = 4'd0; move_col = 4'd4;
        @(negedge clk);
        move_valid = 1'b0;
        check("ngchk.win_seen", win_check, 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check_state("ngchk");

        // Asynchronous reset between edges during CHECK.
        @(negedge clk);
        move_valid = 1'b1; move_row = 4'd3; move_col = 4'd9;
        @(negedge clk);
        move_valid = 1'b0;
        check("arst.in_check", move_ready, 0);
        #2 rst = 1'b1;
        #1;
        model_clear();
        check("arst.chk_board", chk_board, 0);
        check("arst.chk_row", chk_row, 0);
        check_state("arst");
        @(negedge clk);
        rst = 1'b0;
        play(3, 9);

        for (int g = 0; g < 6; g++) begin
            start_game(g[0]);
            no_win = (g % 3 == 2);
            for (int t = 0; t < 120; t++) begin
                int r, c;
                if (g[0]) begin
                    r = $urandom_range(0, 6); c = $urandom_range(0, 6);
                end else begin
                    r = $urandom_range(0, 15); c = $urandom_range(0, 15);
                end
                play(r, c);
            end
        end
        no_win = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
